mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-port, synchronous-read RAM between the pipelined CPU's instruction-fetch stage and its memory stage. It grants one access at a time and drives the RAM port. It returns per-requester valid pulses and stall levels, which the pipeline uses to freeze PC/IFID (IF side) or the whole pipeline (MEM side). A starvation counter guarantees forward progress for fetch under back-to-back data traffic.

---
 rtl/cpu_mem_pkg.sv | 26 ++
 rtl/store_lane_steer.sv | 29 ++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory path: arbiter FSM states, store
// size encodings and the alignment rule used by both arbiter and MEM stage.
package cpu_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF_RD,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_MEM_ERR
    } memPortState_t;

    localparam logic [1:0] BS_WORD = 2'b00;
    localparam logic [1:0] BS_BYTE = 2'b01;
    localparam logic [1:0] BS_HALF = 2'b10;

    // Size code 2'b11 is handled as a word access.
    function automatic logic isMisaligned(input logic [1:0] byteSel, input logic [1:0] addrLo);
        case (byteSel)
            BS_BYTE: return 1'b0;
            BS_HALF: return addrLo[0];
            default: return addrLo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_steer.sv
// Replicates sub-word store data across lanes and builds the byte write mask
// from the access size and the low address bits.
module store_lane_steer
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  ByteSel,
    input  logic [1:0]  AddrLo,
    input  logic [31:0] WData,
    output logic [3:0]  We,
    output logic [31:0] SteerWData
);

    always_comb begin
        We         = 4'b1111;
        SteerWData = WData;
        case (ByteSel)
            BS_BYTE: begin
                We         = 4'b0001 << AddrLo;
                SteerWData = {4{WData[7:0]}};
            end
            BS_HALF: begin
                We         = AddrLo[1] ? 4'b1100 : 4'b0011;
                SteerWData = {2{WData[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM port between instruction fetch and the MEM
// stage; every access is a grant cycle followed by a completion cycle.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned RAM_AW     = 10,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IF_Req,
    input  logic [31:0]       IF_Addr,
    output logic [31:0]       IF_Data,
    output logic              IF_Valid,
    output logic              IF_Stall,
    input  logic              MEM_Req,
    input  logic              MEM_Write,
    input  logic [31:0]       MEM_Addr,
    input  logic [31:0]       MEM_WData,
    input  logic [1:0]        MEM_ByteSel,
    output logic [31:0]       MEM_RData,
    output logic              MEM_Valid,
    output logic              MEM_Err,
    output logic              MEM_Stall,
    output logic              RAM_En,
    output logic [3:0]        RAM_We,
    output logic [RAM_AW-1:0] RAM_Addr,
    output logic [31:0]       RAM_WData,
    input  logic [31:0]       RAM_RData
);

    localparam logic [3:0] StarveMax = 4'(MAX_STARVE);

    memPortState_t state;
    logic [3:0]    starveCnt;
    logic          ifValidQ;
    logic          memValidQ;
    logic          memErrQ;
    logic          grantIf;
    logic          grantMem;
    logic          memMisaligned;
    logic [3:0]    steerWe;
    logic [31:0]   steerWData;
    logic          unusedAddrBits;

    assign unusedAddrBits = ^{IF_Addr[1:0], IF_Addr[31:RAM_AW+2], MEM_Addr[31:RAM_AW+2]};
    assign memMisaligned  = isMisaligned(MEM_ByteSel, MEM_Addr[1:0]);

    store_lane_steer uSteer (
        .ByteSel    (MEM_ByteSel),
        .AddrLo     (MEM_Addr[1:0]),
        .WData      (MEM_WData),
        .We         (steerWe),
        .SteerWData (steerWData)
    );

    // MEM wins contention unless IF has already lost MAX_STARVE times in a row.
    always_comb begin
        grantIf  = 1'b0;
        grantMem = 1'b0;
        if (state == ST_IDLE) begin
            if (MEM_Req && !(IF_Req && starveCnt == StarveMax))
                grantMem = 1'b1;
            else if (IF_Req)
                grantIf = 1'b1;
        end
    end

    always_comb begin
        RAM_En    = 1'b0;
        RAM_We    = '0;
        RAM_Addr  = '0;
        RAM_WData = '0;
        if (!Reset) begin
            if (grantIf) begin
                RAM_En   = 1'b1;
                RAM_Addr = IF_Addr[RAM_AW+1:2];
            end else if (grantMem && !memMisaligned) begin
                RAM_En   = 1'b1;
                RAM_Addr = MEM_Addr[RAM_AW+1:2];
                if (MEM_Write) begin
                    RAM_We    = steerWe;
                    RAM_WData = steerWData;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            starveCnt <= '0;
            ifValidQ  <= 1'b0;
            memValidQ <= 1'b0;
            memErrQ   <= 1'b0;
        end else begin
            ifValidQ  <= 1'b0;
            memValidQ <= 1'b0;
            memErrQ   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grantIf) begin
                        state     <= ST_IF_RD;
                        ifValidQ  <= 1'b1;
                        starveCnt <= '0;
                    end else if (grantMem) begin
                        memValidQ <= 1'b1;
                        if (IF_Req && starveCnt < StarveMax)
                            starveCnt <= starveCnt + 4'd1;
                        if (memMisaligned) begin
                            state   <= ST_MEM_ERR;
                            memErrQ <= 1'b1;
                        end else if (MEM_Write) begin
                            state <= ST_MEM_WR;
                        end else begin
                            state <= ST_MEM_RD;
                        end
                    end
                end
                ST_IF_RD, ST_MEM_RD, ST_MEM_WR, ST_MEM_ERR: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Completion pulses are masked while Reset is high so an in-flight access is discarded.
    assign IF_Valid  = ifValidQ & ~Reset;
    assign MEM_Valid = memValidQ & ~Reset;
    assign MEM_Err   = memErrQ & ~Reset;
    assign IF_Data   = RAM_RData;
    assign MEM_RData = RAM_RData;
    assign IF_Stall  = IF_Req & ~IF_Valid;
    assign MEM_Stall = MEM_Req & ~MEM_Valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level
// model of the shared RAM port (two-cycle occupancy, starvation limit, lane rules).
module tb_mem_port_arbiter;

    localparam int MS = 2;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        IF_Req = 1'b0;
    logic [31:0] IF_Addr = '0;
    logic [31:0] IF_Data;
    logic        IF_Valid;
    logic        IF_Stall;
    logic        MEM_Req = 1'b0;
    logic        MEM_Write = 1'b0;
    logic [31:0] MEM_Addr = '0;
    logic [31:0] MEM_WData = '0;
    logic [1:0]  MEM_ByteSel = '0;
    logic [31:0] MEM_RData;
    logic        MEM_Valid;
    logic        MEM_Err;
    logic        MEM_Stall;
    logic        RAM_En;
    logic [3:0]  RAM_We;
    logic [9:0]  RAM_Addr;
    logic [31:0] RAM_WData;
    logic [31:0] RAM_RData;

    logic [31:0] ram       [0:1023];
    logic [31:0] ramPreset [0:1023];
    logic [31:0] refMem    [0:1023];
    logic        ramLoad = 1'b0;

    int nChecks = 0;
    int nFail   = 0;

    always #5 Clock = ~Clock;

    mem_port_arbiter #(.RAM_AW(10), .MAX_STARVE(MS)) dut (
        .Clock(Clock), .Reset(Reset),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Data(IF_Data),
        .IF_Valid(IF_Valid), .IF_Stall(IF_Stall),
        .MEM_Req(MEM_Req), .MEM_Write(MEM_Write), .MEM_Addr(MEM_Addr),
        .MEM_WData(MEM_WData), .MEM_ByteSel(MEM_ByteSel), .MEM_RData(MEM_RData),
        .MEM_Valid(MEM_Valid), .MEM_Err(MEM_Err), .MEM_Stall(MEM_Stall),
        .RAM_En(RAM_En), .RAM_We(RAM_We), .RAM_Addr(RAM_Addr),
        .RAM_WData(RAM_WData), .RAM_RData(RAM_RData)
    );

    // Synchronous-read, byte-writable RAM behind the port
    always @(posedge Clock) begin
        if (ramLoad) begin
            for (int i = 0; i < 1024; i++) ram[i] <= ramPreset[i];
        end else if (RAM_En) begin
            if (RAM_We == 4'b0000)
                RAM_RData <= ram[RAM_Addr];
            else
                for (int b = 0; b < 4; b++)
                    if (RAM_We[b]) ram[RAM_Addr][8*b +: 8] <= RAM_WData[8*b +: 8];
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic setIdle();
        IF_Req = 1'b0; IF_Addr = '0;
        MEM_Req = 1'b0; MEM_Write = 1'b0; MEM_Addr = '0; MEM_WData = '0; MEM_ByteSel = '0;
    endtask

    task automatic memDrive(input logic wr, input logic [1:0] bs, input logic [31:0] a, input logic [31:0] wd);
        MEM_Req = 1'b1; MEM_Write = wr; MEM_ByteSel = bs; MEM_Addr = a; MEM_WData = wd;
    endtask

    function automatic logic refMisaligned(input logic [1:0] bs, input logic [31:0] a);
        if (bs == 2'd1) return 1'b0;
        if (bs == 2'd2) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] refWe(input logic [1:0] bs, input logic [31:0] a);
        int unsigned lane;
        lane = a % 4;
        if (bs == 2'd1) return 4'(1 << lane);
        if (bs == 2'd2) return (lane >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] refWData(input logic [1:0] bs, input logic [31:0] wd);
        if (bs == 2'd1) return (wd & 32'hFF) * 32'h01010101;
        if (bs == 2'd2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    task automatic test_reset();
        Reset = 1'b1; ramLoad = 1'b1;
        IF_Req = 1'b1; IF_Addr = 32'h40;
        memDrive(1'b1, 2'd0, 32'h10, 32'h11111111);
        repeat (2) begin
            @(negedge Clock);
            nChecks++; if (RAM_En !== 1'b0) begin nFail++; $display("FAIL reset_ram_en: got %b want 0", RAM_En); end
            nChecks++; if (RAM_We !== 4'b0000) begin nFail++; $display("FAIL reset_ram_we: got %b want 0000", RAM_We); end
            nChecks++; if ({IF_Valid, MEM_Valid, MEM_Err} !== 3'b000) begin nFail++; $display("FAIL reset_valids: got %b want 000", {IF_Valid, MEM_Valid, MEM_Err}); end
            nChecks++; if ({IF_Stall, MEM_Stall} !== 2'b11) begin nFail++; $display("FAIL reset_stalls: got %b want 11", {IF_Stall, MEM_Stall}); end
            tick();
        end
        ramLoad = 1'b0; Reset = 1'b0; setIdle();
        @(negedge Clock);
        nChecks++; if ({RAM_En, IF_Stall, MEM_Stall} !== 3'b000) begin nFail++; $display("FAIL post_reset_idle: got %b want 000", {RAM_En, IF_Stall, MEM_Stall}); end
        tick();
    endtask

    task automatic test_if_fetch();
        IF_Req = 1'b1; IF_Addr = 32'h40;
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b1 || RAM_Addr !== 10'h010 || RAM_We !== 4'b0000) begin nFail++; $display("FAIL fetch_grant: got en=%b addr=%h we=%b want 1/010/0000", RAM_En, RAM_Addr, RAM_We); end
        nChecks++; if (IF_Stall !== 1'b1 || IF_Valid !== 1'b0) begin nFail++; $display("FAIL fetch_c0: got stall=%b valid=%b want 1/0", IF_Stall, IF_Valid); end
        tick();
        @(negedge Clock);
        nChecks++; if (IF_Valid !== 1'b1 || IF_Data !== 32'hDEADBEEF) begin nFail++; $display("FAIL fetch_data: got valid=%b data=%h want 1/deadbeef", IF_Valid, IF_Data); end
        nChecks++; if (IF_Stall !== 1'b0 || RAM_En !== 1'b0) begin nFail++; $display("FAIL fetch_c1: got stall=%b en=%b want 0/0", IF_Stall, RAM_En); end
        tick();
        IF_Req = 1'b0;
        @(negedge Clock);
        nChecks++; if (IF_Valid !== 1'b0) begin nFail++; $display("FAIL fetch_pulse: got %b want 0", IF_Valid); end
        tick();
    endtask

    task automatic test_both_request();
        IF_Req = 1'b1; IF_Addr = 32'h46;
        memDrive(1'b0, 2'd0, 32'h80, 32'h0);
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b1 || RAM_Addr !== 10'h020) begin nFail++; $display("FAIL both_mem_first: got en=%b addr=%h want 1/020", RAM_En, RAM_Addr); end
        tick();
        @(negedge Clock);
        nChecks++; if (MEM_Valid !== 1'b1 || MEM_RData !== 32'h13579BDF || IF_Valid !== 1'b0) begin nFail++; $display("FAIL both_mem_done: got mv=%b data=%h iv=%b want 1/13579bdf/0", MEM_Valid, MEM_RData, IF_Valid); end
        nChecks++; if (IF_Stall !== 1'b1) begin nFail++; $display("FAIL both_if_stall: got %b want 1", IF_Stall); end
        tick();
        MEM_Req = 1'b0;
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b1 || RAM_Addr !== 10'h011) begin nFail++; $display("FAIL both_if_grant: got en=%b addr=%h want 1/011", RAM_En, RAM_Addr); end
        tick();
        @(negedge Clock);
        nChecks++; if (IF_Valid !== 1'b1 || IF_Data !== 32'hCAFEF00D) begin nFail++; $display("FAIL both_if_done: got valid=%b data=%h want 1/cafef00d", IF_Valid, IF_Data); end
        tick();
        IF_Req = 1'b0;
    endtask

    task automatic test_starvation();
        logic memWins [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        IF_Req = 1'b1; IF_Addr = 32'h0;
        memDrive(1'b0, 2'd0, 32'h80, 32'h0);
        for (int g = 0; g < 6; g++) begin
            @(negedge Clock);
            nChecks++; if (RAM_En !== 1'b1 || RAM_Addr !== (memWins[g] ? 10'h020 : 10'h000)) begin nFail++; $display("FAIL starve_grant%0d: got en=%b addr=%h want mem=%b", g, RAM_En, RAM_Addr, memWins[g]); end
            tick();
            @(negedge Clock);
            nChecks++; if (MEM_Valid !== memWins[g] || IF_Valid !== !memWins[g]) begin nFail++; $display("FAIL starve_done%0d: got mv=%b iv=%b want mem=%b", g, MEM_Valid, IF_Valid, memWins[g]); end
            tick();
        end
        setIdle();
    endtask

    task automatic test_store_steer();
        memDrive(1'b1, 2'd1, 32'h103, 32'h123456A5);
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b1 || RAM_We !== 4'b1000 || RAM_WData !== 32'hA5A5A5A5 || RAM_Addr !== 10'h040) begin nFail++; $display("FAIL store_byte: got en=%b we=%b wd=%h addr=%h want 1/1000/a5a5a5a5/040", RAM_En, RAM_We, RAM_WData, RAM_Addr); end
        tick();
        @(negedge Clock);
        nChecks++; if (MEM_Valid !== 1'b1 || MEM_Err !== 1'b0 || RAM_En !== 1'b0) begin nFail++; $display("FAIL store_byte_done: got v=%b e=%b en=%b want 1/0/0", MEM_Valid, MEM_Err, RAM_En); end
        tick();
        memDrive(1'b1, 2'd2, 32'h102, 32'hABCD1234);
        @(negedge Clock);
        nChecks++; if (RAM_We !== 4'b1100 || RAM_WData !== 32'h12341234 || RAM_Addr !== 10'h040) begin nFail++; $display("FAIL store_half: got we=%b wd=%h addr=%h want 1100/12341234/040", RAM_We, RAM_WData, RAM_Addr); end
        tick();
        tick();
        memDrive(1'b0, 2'd0, 32'h100, 32'h0);
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b1 || RAM_We !== 4'b0000) begin nFail++; $display("FAIL load_we: got en=%b we=%b want 1/0000", RAM_En, RAM_We); end
        tick();
        @(negedge Clock);
        nChecks++; if (MEM_Valid !== 1'b1 || MEM_RData !== 32'h12340000) begin nFail++; $display("FAIL store_readback: got v=%b data=%h want 1/12340000", MEM_Valid, MEM_RData); end
        tick();
        setIdle();
    endtask

    task automatic test_misaligned();
        memDrive(1'b0, 2'd2, 32'h101, 32'h0);
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b0 || MEM_Stall !== 1'b1 || MEM_Valid !== 1'b0) begin nFail++; $display("FAIL misal_grant: got en=%b stall=%b v=%b want 0/1/0", RAM_En, MEM_Stall, MEM_Valid); end
        tick();
        @(negedge Clock);
        nChecks++; if (MEM_Valid !== 1'b1 || MEM_Err !== 1'b1 || MEM_Stall !== 1'b0 || RAM_En !== 1'b0) begin nFail++; $display("FAIL misal_done: got v=%b e=%b stall=%b en=%b want 1/1/0/0", MEM_Valid, MEM_Err, MEM_Stall, RAM_En); end
        tick();
        setIdle(); IF_Req = 1'b1; IF_Addr = 32'h40;
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b1 || MEM_Err !== 1'b0) begin nFail++; $display("FAIL misal_idle: got en=%b e=%b want 1/0", RAM_En, MEM_Err); end
        tick();
        tick();
        IF_Req = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        IF_Req = 1'b1; IF_Addr = 32'h40;
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b1) begin nFail++; $display("FAIL midrst_grant: got %b want 1", RAM_En); end
        tick();
        Reset = 1'b1;
        @(negedge Clock);
        nChecks++; if (IF_Valid !== 1'b0) begin nFail++; $display("FAIL midrst_no_valid: got %b want 0", IF_Valid); end
        tick();
        Reset = 1'b0; IF_Req = 1'b0;
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b0 || IF_Valid !== 1'b0) begin nFail++; $display("FAIL midrst_idle: got en=%b v=%b want 0/0", RAM_En, IF_Valid); end
        tick();
        Reset = 1'b1; memDrive(1'b1, 2'd0, 32'h44, 32'h55AA55AA);
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b0 || RAM_We !== 4'b0000 || MEM_Stall !== 1'b1) begin nFail++; $display("FAIL rst_write_gate: got en=%b we=%b stall=%b want 0/0000/1", RAM_En, RAM_We, MEM_Stall); end
        tick();
        Reset = 1'b0; MEM_Req = 1'b0;
        @(negedge Clock);
        nChecks++; if (MEM_Valid !== 1'b0) begin nFail++; $display("FAIL rst_write_no_valid: got %b want 0", MEM_Valid); end
        tick();
        // Drive the starvation count to its limit, then check reset clears it
        IF_Req = 1'b1; IF_Addr = 32'h0; memDrive(1'b0, 2'd0, 32'h80, 32'h0);
        repeat (4) tick();
        Reset = 1'b1;
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b0) begin nFail++; $display("FAIL rst_grant_gate: got %b want 0", RAM_En); end
        tick();
        Reset = 1'b0;
        @(negedge Clock);
        nChecks++; if (RAM_En !== 1'b1 || RAM_Addr !== 10'h020) begin nFail++; $display("FAIL rst_starve_clear: got en=%b addr=%h want 1/020", RAM_En, RAM_Addr); end
        tick();
        tick();
        MEM_Req = 1'b0;
        tick();
        tick();
        setIdle();
    endtask

    task automatic test_random();
        int          pend;
        int          grant;
        int          starve;
        int          ifAge;
        logic        ifDone;
        logic        memDone;
        logic        eEn;
        logic [3:0]  eWe;
        logic [31:0] eWd;
        logic [9:0]  eAddr;
        logic [9:0]  pendWord;
        for (int i = 0; i < 1024; i++) begin
            ramPreset[i] = $urandom;
            refMem[i]    = ramPreset[i];
        end
        setIdle(); Reset = 1'b1; ramLoad = 1'b1;
        tick();
        ramLoad = 1'b0;
        tick();
        Reset = 1'b0;
        pend = 0; starve = 0; ifAge = 0; ifDone = 1'b0; memDone = 1'b0; pendWord = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!IF_Req || ifDone) begin
                IF_Req  = ($urandom_range(0, 3) != 0);
                IF_Addr = $urandom_range(0, 255);
                ifAge   = 0;
            end else begin
                ifAge++;
            end
            if (!MEM_Req || memDone) begin
                MEM_Req     = ($urandom_range(0, 3) != 0);
                MEM_Write   = 1'($urandom_range(0, 1));
                MEM_ByteSel = 2'($urandom_range(0, 3));
                MEM_Addr    = $urandom_range(0, 255);
                MEM_WData   = $urandom;
            end
            ifDone  = (pend == 1);
            memDone = (pend >= 2);
            grant = 0; eEn = 1'b0; eWe = '0; eWd = '0; eAddr = '0;
            if (pend == 0) begin
                if (MEM_Req && !(IF_Req && starve == MS)) begin
                    if (IF_Req && starve < MS) starve++;
                    if (refMisaligned(MEM_ByteSel, MEM_Addr)) grant = 4;
                    else grant = MEM_Write ? 3 : 2;
                end else if (IF_Req) begin
                    grant  = 1;
                    starve = 0;
                end
            end
            if (grant == 1) begin
                eEn = 1'b1; eAddr = 10'(IF_Addr >> 2);
            end else if (grant == 2 || grant == 3) begin
                eEn = 1'b1; eAddr = 10'(MEM_Addr >> 2);
                if (grant == 3) begin
                    eWe = refWe(MEM_ByteSel, MEM_Addr);
                    eWd = refWData(MEM_ByteSel, MEM_WData);
                end
            end
            @(negedge Clock);
            nChecks++; if (RAM_En !== eEn) begin nFail++; $display("FAIL rnd_en cyc%0d: got %b want %b", cyc, RAM_En, eEn); end
            if (eEn) begin
                nChecks++; if (RAM_Addr !== eAddr) begin nFail++; $display("FAIL rnd_addr cyc%0d: got %h want %h", cyc, RAM_Addr, eAddr); end
            end
            nChecks++; if (RAM_We !== eWe) begin nFail++; $display("FAIL rnd_we cyc%0d: got %b want %b", cyc, RAM_We, eWe); end
            if (grant == 3) begin
                nChecks++; if (RAM_WData !== eWd) begin nFail++; $display("FAIL rnd_wdata cyc%0d: got %h want %h", cyc, RAM_WData, eWd); end
            end
            nChecks++; if (IF_Valid !== ifDone || MEM_Valid !== memDone || MEM_Err !== (pend == 4)) begin nFail++; $display("FAIL rnd_valid cyc%0d: got iv=%b mv=%b e=%b want %b/%b/%b", cyc, IF_Valid, MEM_Valid, MEM_Err, ifDone, memDone, pend == 4); end
            nChecks++; if (IF_Stall !== (IF_Req && !ifDone) || MEM_Stall !== (MEM_Req && !memDone)) begin nFail++; $display("FAIL rnd_stall cyc%0d: got %b%b", cyc, IF_Stall, MEM_Stall); end
            if (ifDone) begin
                nChecks++; if (IF_Data !== refMem[pendWord]) begin nFail++; $display("FAIL rnd_ifdata cyc%0d: got %h want %h", cyc, IF_Data, refMem[pendWord]); end
                nChecks++; if (ifAge > 2 * (MS + 1)) begin nFail++; $display("FAIL rnd_if_latency cyc%0d: got %0d want <= %0d", cyc, ifAge, 2 * (MS + 1)); end
            end
            if (pend == 2) begin
                nChecks++; if (MEM_RData !== refMem[pendWord]) begin nFail++; $display("FAIL rnd_memdata cyc%0d: got %h want %h", cyc, MEM_RData, refMem[pendWord]); end
            end
            if (grant == 3)
                for (int b = 0; b < 4; b++)
                    if (eWe[b]) refMem[eAddr][8*b +: 8] = eWd[8*b +: 8];
            pend     = grant;
            pendWord = eAddr;
            tick();
        end
        setIdle();
        repeat (2) tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ramPreset[i] = 32'(i) * 32'h01000193;
        ramPreset[10'h010] = 32'hDEADBEEF;
        ramPreset[10'h011] = 32'hCAFEF00D;
        ramPreset[10'h020] = 32'h13579BDF;
        ramPreset[10'h040] = 32'h00000000;
        test_reset();
        test_if_fetch();
        test_both_request();
        test_starvation();
        test_store_steer();
        test_misaligned();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
